seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Multiplexed driver for an N-digit common-anode 7-segment display. Uses one shared active-low segment bus and per-digit active-low anode enables.
- Each digit is a 4-bit hex value, captured into a shadow register on a load strobe. The display scans one digit at a time at a parametrised rate.
- Supports per-digit decimal point and blanking.
- Sits between the counter/status datapath and the board display pins. Replaces the single-digit hex decoder.

Parameters:
- NUM_DIGITS, 8, digit count; legal range 1..16.
- SCAN_DIV, 100000, CLK cycles each digit stays selected; must be >= 2 (use 4 in simulation).

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  asynchronous, active-high reset.
- LOAD  input  1  one-cycle strobe; captures VALUE, DP_MASK and BLANK_MASK into the shadow registers.
- VALUE  input  4*NUM_DIGITS  hex digits; digit i = VALUE[4i+3:4i]; digit 0 is the rightmost.
- DP_MASK  input  NUM_DIGITS  1 = decimal point lit on digit i.
- BLANK_MASK  input  NUM_DIGITS  1 = digit i dark, including its dp.
- AN  output  NUM_DIGITS  active-low anode enables, registered.
- SEG  output  8  active-low segments, registered; SEG[7:1] = a..g, SEG[0] = dp.

Behaviour:
- Reset (async, takes effect immediately, also mid-scan):
  - AN = all ones, SEG = 8'hFF, scan counter = 0, digit index = 0.
  - Shadow VALUE = 0, shadow DP = 0, shadow BLANK = all ones, so the display stays dark until the first LOAD.
- Shadow registers:
  - LOAD high at cycle t → shadow updated at edge t+1.
  - VALUE, DP_MASK and BLANK_MASK are ignored when LOAD is low.
  - LOAD with RST high is ignored.
- Scan counter:
  - Counts 0..SCAN_DIV-1. tick = (cnt == SCAN_DIV-1).
  - On tick: cnt ← 0 and idx ← idx+1; idx wraps from NUM_DIGITS-1 to 0.
  - idx width = max(1, clog2(NUM_DIGITS)).
  - With NUM_DIGITS = 1, idx stays 0.
- Output register (loaded every cycle from idx and shadow, one cycle of latency):
  - AN and SEG change on the same edge, so there is no cross-digit ghosting.
  - If shadow BLANK[idx] = 1: AN ← all ones and SEG ← 8'hFF. Scan timing is unaffected.
  - Otherwise: AN ← all ones with bit idx = 0; SEG ← {glyph(digit)[7:1], ~DP[idx]}.
- Glyph table (SEG[7:0], dp off):
  - 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F
  - 8=01, 9=09, A=11, b=C1, C=63, d=85, E=61, F=71
- Full period = NUM_DIGITS*SCAN_DIV cycles; each digit is lit for exactly SCAN_DIV cycles.
- LOAD in mid-slot: the new pattern appears on the edge after the shadow update, even within the current slot. No partial-digit mixing is possible.
- LOAD coincident with tick: both take effect; the next digit shows the new data one cycle later.

Optional Feature:
- Macro: SEG7_LZ_SUPPRESS_EN.
- Defined: leading-zero suppression.
  - Digit i (i > 0) is treated as blanked when its value and all higher digits' values are 0 and their DP bits are 0.
  - A set DP bit ends the suppression run. Digit 0 is never suppressed.
  - Computed from the shadow registers only; timing is unchanged.
- Not defined: all non-blanked digits display, including leading zeros.

Decomposition:
- Package seg7_pkg:
  - the 16 glyph constants;
  - SEG_OFF = 8'hFF;
  - function glyph(4-bit) → 8-bit.
- Sub-module seg7_glyph: purely combinational; inputs digit[3:0] and dp; output seg[7:0]. Instantiated once on the mux output.
- Scan counter, shadow registers, LZ logic and output registers stay in the top module.

Test Plan:
1. Reset: RST high mid-scan → AN = FF and SEG = FF within the same cycle. After release with no LOAD → AN stays FF for 64 cycles.
2. Basic scan (N = 8, SCAN_DIV = 4): LOAD VALUE = 32'h01234567, DP = 0, BLANK = 0.
   - AN steps FE, FD, … 7F, each held 4 cycles, and wraps to FE after 32 cycles.
   - SEG: digit0 = 1F, digit3 = 99, digit7 = 03.
3. DP and blanking: DP_MASK = 04 → digit2 SEG = 48. BLANK_MASK = 80 → during slot 7, AN = FF and SEG = FF, and slot length stays 4.
4. Shadow isolation: change VALUE to 32'hFFFFFFFF without LOAD → display unchanged. Pulse LOAD mid-slot → that slot shows 71 starting 2 cycles after the strobe.
5. Leading-zero suppression, VALUE = 32'h000000A0:
   - With macro: digits 7..2 dark, digit1 = 11, digit0 = 03.
   - With VALUE = 0: only digit0 lit (03).
   - With DP_MASK = 08: digits 3..0 lit.
   - Without macro: all eight digits lit.
6. Edge sizing: N = 1, SCAN_DIV = 2 → AN constantly 0 after LOAD; a LOAD coincident with tick updates SEG one cycle later.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph table and segment constants for the multiplexed 7-segment driver.
// Glyphs are active-low {a,b,c,d,e,f,g,dp} with the dp bit held off (1).
package seg7_pkg;

  localparam logic [7:0] GLYPH_0 = 8'h03;
  localparam logic [7:0] GLYPH_1 = 8'h9F;
  localparam logic [7:0] GLYPH_2 = 8'h25;
  localparam logic [7:0] GLYPH_3 = 8'h0D;
  localparam logic [7:0] GLYPH_4 = 8'h99;
  localparam logic [7:0] GLYPH_5 = 8'h49;
  localparam logic [7:0] GLYPH_6 = 8'h41;
  localparam logic [7:0] GLYPH_7 = 8'h1F;
  localparam logic [7:0] GLYPH_8 = 8'h01;
  localparam logic [7:0] GLYPH_9 = 8'h09;
  localparam logic [7:0] GLYPH_A = 8'h11;
  localparam logic [7:0] GLYPH_B = 8'hC1;
  localparam logic [7:0] GLYPH_C = 8'h63;
  localparam logic [7:0] GLYPH_D = 8'h85;
  localparam logic [7:0] GLYPH_E = 8'h61;
  localparam logic [7:0] GLYPH_F = 8'h71;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    logic [7:0] g;
    g = SEG_OFF;
    case (d)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      4'hF: g = GLYPH_F;
      default: g = SEG_OFF;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Hex digit plus decimal point to active-low segment pattern; purely combinational.
// Zero latency, no flow control.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] base;

  assign base = glyph(digit);
  assign seg  = (base & 8'hFE) | {7'b0, ~dp};

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit common-anode scan driver; SEG7_LZ_SUPPRESS_EN adds leading-zero suppression.
// One cycle from shadow/index to registered AN/SEG; no backpressure, LOAD always accepted.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000
)
(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    LOAD,
  input  logic [4*NUM_DIGITS-1:0] VALUE,
  input  logic [NUM_DIGITS-1:0]   DP_MASK,
  input  logic [NUM_DIGITS-1:0]   BLANK_MASK,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [7:0]              SEG
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    tick;
  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [NUM_DIGITS-1:0]   lz;
  logic [NUM_DIGITS-1:0]   eff_blank;
  logic [3:0]              sel_digit;
  logic                    sel_dp;
  logic                    sel_blank;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [7:0]              glyph_seg;

  assign tick = (cnt == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Blank-all reset keeps the display dark until the first LOAD.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_value <= '0;
      sh_dp    <= '0;
      sh_blank <= '1;
    end else if (LOAD) begin
      sh_value <= VALUE;
      sh_dp    <= DP_MASK;
      sh_blank <= BLANK_MASK;
    end
  end

`ifdef SEG7_LZ_SUPPRESS_EN
  logic run;

  // Walk down from the top digit; a nonzero value or a lit dp ends the run.
  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run = run & (sh_value[4*i +: 4] == 4'h0) & ~sh_dp[i];
      if (i > 0) lz[i] = run;
    end
  end
`else
  assign lz = '0;
`endif

  assign eff_blank = sh_blank | lz;

  always_comb begin
    sel_digit = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b1;
    an_nxt    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_digit = sh_value[4*i +: 4];
        sel_dp    = sh_dp[i];
        sel_blank = eff_blank[i];
        an_nxt[i] = 1'b0;
      end
    end
  end

  seg7_glyph u_glyph (
    .digit (sel_digit),
    .dp    (sel_dp),
    .seg   (glyph_seg)
  );

  // AN and SEG share one register stage so a digit switch never ghosts.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      AN  <= '1;
      SEG <= SEG_OFF;
    end else if (sel_blank) begin
      AN  <= '1;
      SEG <= SEG_OFF;
    end else begin
      AN  <= an_nxt;
      SEG <= glyph_seg;
    end
  end

endmodule
